// File: rtl/processor_pkg.sv
// processor_pkg: shared definitions for the processor front end.
// Holds datapath op codes, RV32 opcode/funct constants, the ECALL word,
// the issue FSM state enum and the decoded-instruction payload struct.
package processor_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned OP_W   = 7;

    // Datapath operation codes
    localparam logic [OP_W-1:0] OP_NOP   = 7'b0000000;
    localparam logic [OP_W-1:0] OP_STORE = 7'b0000001;
    localparam logic [OP_W-1:0] OP_ADD   = 7'b0000010;
    localparam logic [OP_W-1:0] OP_SUB   = 7'b0000011;

    // RV32 encoding constants
    localparam logic [6:0]      RV_OPC_OP     = 7'b0110011;
    localparam logic [6:0]      RV_OPC_OP_IMM = 7'b0010011;
    localparam logic [2:0]      RV_F3_ADD     = 3'b000;
    localparam logic [6:0]      RV_F7_ADD     = 7'b0000000;
    localparam logic [6:0]      RV_F7_SUB     = 7'b0100000;
    localparam logic [XLEN-1:0] RV_ECALL      = 32'h0000_0073;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } issue_state_e;

    // One decoded instruction as presented to the datapath
    typedef struct packed {
        logic              legal;
        logic              ecall;
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   imm;
    } dec_t;

    function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
        return {{(XLEN-12){v[11]}}, v};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: purely combinational RV32 word-to-fields mapping.
// Ports:
//   instr    in  32  instruction word
//   legal_c  out 1   word is an issuable add/sub/li
//   ecall_c  out 1   word is ECALL
//   op_c     out 7   datapath op code (OP_NOP when not legal)
//   rs1_c    out 5   source 1 (li: destination register of the store)
//   rs2_c    out 5   source 2
//   rd_c     out 5   destination (add/sub only)
//   imm_c    out 32  sign-extended immediate (li only, else 0)
module instr_decoder
    import processor_pkg::*;
(
    input  logic [31:0] instr,
    output logic        legal_c,
    output logic        ecall_c,
    output logic [6:0]  op_c,
    output logic [4:0]  rs1_c,
    output logic [4:0]  rs2_c,
    output logic [4:0]  rd_c,
    output logic [31:0] imm_c
);

    logic [6:0] opc_c;
    logic [2:0] f3_c;
    logic [6:0] f7_c;

    assign opc_c = instr[6:0];
    assign f3_c  = instr[14:12];
    assign f7_c  = instr[31:25];

    // Field extraction; every field stays zero unless the encoding is recognised
    always_comb begin
        legal_c = 1'b0;
        ecall_c = 1'b0;
        op_c    = OP_NOP;
        rs1_c   = '0;
        rs2_c   = '0;
        rd_c    = '0;
        imm_c   = '0;
        if (instr == RV_ECALL) begin
            ecall_c = 1'b1;
        end else if (opc_c == RV_OPC_OP && f3_c == RV_F3_ADD &&
                     (f7_c == RV_F7_ADD || f7_c == RV_F7_SUB)) begin
            legal_c = 1'b1;
            op_c    = (f7_c == RV_F7_SUB) ? OP_SUB : OP_ADD;
            rs1_c   = instr[19:15];
            rs2_c   = instr[24:20];
            rd_c    = instr[11:7];
        end else if (opc_c == RV_OPC_OP_IMM && f3_c == RV_F3_ADD &&
                     instr[19:15] == 5'd0) begin
            // li: the datapath stores rd_in into the register named on rs1
            legal_c = 1'b1;
            op_c    = OP_STORE;
            rs1_c   = instr[11:7];
            imm_c   = sext12(instr[31:20]);
        end
    end

endmodule

// File: rtl/instr_issue_unit.sv
// instr_issue_unit: instruction buffer, sequential fetch/decode and
// valid/ready issue of add/sub/li operations to the datapath.
// Optional feature macro: ISSUE_ILLEGAL_TRAP_EN (illegal word halts the run;
// when undefined the illegal word is skipped and execution continues).
// Ports:
//   clk, rst_n              clock / async active-low reset
//   prog_we/addr/data       buffer write port (honoured in IDLE/HALT only)
//   start                   run pulse (honoured in IDLE/HALT only)
//   issue_ready             datapath accepts the presented operation
//   issue_valid             operation presented
//   rs1, rs2, rd, rd_in     operation fields
//   op_code                 datapath op, 0 whenever issue_valid is 0
//   busy                    FETCH or ISSUE
//   done, pc_overflow       halted on ecall / ran past the last entry
//   illegal                 unsupported encoding seen since start
//   pc                      current fetch address
//   issued_cnt              accepted operations since start, saturating
module instr_issue_unit
    import processor_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [31:0]      prog_data,
    input  logic             start,
    input  logic             issue_ready,
    output logic             issue_valid,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [31:0]      rd_in,
    output logic [6:0]       op_code,
    output logic             busy,
    output logic             done,
    output logic             pc_overflow,
    output logic             illegal,
    output logic [AW-1:0]    pc,
    output logic [CNT_W-1:0] issued_cnt
);

    localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

    logic [31:0] mem_q [DEPTH];

    issue_state_e     state_q, state_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             issue_valid_q, issue_valid_d;
    logic [6:0]       op_code_q, op_code_d;
    logic [4:0]       rs1_q, rs1_d;
    logic [4:0]       rs2_q, rs2_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      rd_in_q, rd_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             illegal_q, illegal_d;

    logic             mem_we_c;
    logic             advance_c;
    logic [31:0]      fetch_word_c;
    dec_t             dec_c;

    assign fetch_word_c = mem_q[pc_q];

    instr_decoder u_dec (
        .instr   (fetch_word_c),
        .legal_c (dec_c.legal),
        .ecall_c (dec_c.ecall),
        .op_c    (dec_c.op),
        .rs1_c   (dec_c.rs1),
        .rs2_c   (dec_c.rs2),
        .rd_c    (dec_c.rd),
        .imm_c   (dec_c.imm)
    );

    // Instruction buffer; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        cnt_d         = cnt_q;
        issue_valid_d = issue_valid_q;
        op_code_d     = op_code_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rd_d          = rd_q;
        rd_in_d       = rd_in_q;
        done_d        = done_q;
        ovf_d         = ovf_q;
        illegal_d     = illegal_q;
        mem_we_c      = 1'b0;
        advance_c     = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                mem_we_c = prog_we;
                if (start) begin
                    pc_d      = '0;
                    cnt_d     = '0;
                    done_d    = 1'b0;
                    ovf_d     = 1'b0;
                    illegal_d = 1'b0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (dec_c.ecall) begin
                    done_d  = 1'b1;
                    state_d = ST_HALT;
                end else if (dec_c.legal) begin
                    issue_valid_d = 1'b1;
                    op_code_d     = dec_c.op;
                    rs1_d         = dec_c.rs1;
                    rs2_d         = dec_c.rs2;
                    rd_d          = dec_c.rd;
                    rd_in_d       = dec_c.imm;
                    state_d       = ST_ISSUE;
                end else begin
                    illegal_d = 1'b1;
`ifdef ISSUE_ILLEGAL_TRAP_EN
                    state_d = ST_HALT;
`else
                    advance_c = 1'b1;
`endif
                end
            end
            ST_ISSUE: begin
                if (issue_ready) begin
                    issue_valid_d = 1'b0;
                    op_code_d     = OP_NOP;
                    rs1_d         = '0;
                    rs2_d         = '0;
                    rd_d          = '0;
                    rd_in_d       = '0;
                    cnt_d         = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                    advance_c     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Move to the next entry, or stop when the last one has been consumed
        if (advance_c) begin
            if (pc_q == PC_LAST) begin
                ovf_d   = 1'b1;
                state_d = ST_HALT;
            end else begin
                pc_d    = pc_q + AW'(1);
                state_d = ST_FETCH;
            end
        end

        busy_d = (state_d == ST_FETCH) || (state_d == ST_ISSUE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            cnt_q         <= '0;
            issue_valid_q <= 1'b0;
            op_code_q     <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            rd_in_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ovf_q         <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            cnt_q         <= cnt_d;
            issue_valid_q <= issue_valid_d;
            op_code_q     <= op_code_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
            rd_in_q       <= rd_in_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            ovf_q         <= ovf_d;
            illegal_q     <= illegal_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign op_code     = op_code_q;
    assign rs1         = rs1_q;
    assign rs2         = rs2_q;
    assign rd          = rd_q;
    assign rd_in       = rd_in_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pc_overflow = ovf_q;
    assign illegal     = illegal_q;
    assign pc          = pc_q;
    assign issued_cnt  = cnt_q;

endmodule

// File: doc/instr_issue_unit.md
Name: instr_issue_unit

Overview:
- Upstream stage of the processor datapath.
- Holds a small program in a register-array instruction buffer, fetches sequentially from pc 0 and decodes RV32 R-type add/sub and the addi-from-x0 load-immediate.
- Issues each decoded operation to the datapath over a valid/ready handshake, driving its rs1, rs2, rd_in and op_code inputs.
- Halts on ecall or at the end of the buffer.

Parameters:
- DEPTH, 32, instruction buffer entries (power of 2, ≥2).
- AW, $clog2(DEPTH), buffer/pc address width.
- CNT_W, 16, issued-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  buffer write strobe.
- prog_addr  in  AW  buffer write address.
- prog_data  in  32  instruction word to write.
- start  in  1  run pulse.
- issue_ready  in  1  datapath accepts operation.
- issue_valid  out  1  operation presented.
- rs1  out  5  source 1 / store target address.
- rs2  out  5  source 2 address.
- rd  out  5  destination field (add/sub).
- rd_in  out  32  immediate value (load-immediate only, else 0).
- op_code  out  7  datapath operation; 0 whenever issue_valid=0.
- busy  out  1  state is FETCH or ISSUE.
- done  out  1  halted normally (ecall).
- pc_overflow  out  1  ran past last entry without ecall.
- illegal  out  1  unsupported encoding seen (sticky until start).
- pc  out  AW  current fetch address.
- issued_cnt  out  CNT_W  accepted operations since start, saturating.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- Reset values: state IDLE; every output 0. Buffer contents are not reset.
- Reset mid-run: the run is aborted immediately with no partial issue; buffer contents are retained.
- FSM states: IDLE, FETCH, ISSUE, HALT.
- IDLE/HALT:
  - prog_we writes prog_data into mem[prog_addr]. prog_we is ignored in FETCH and ISSUE.
  - start: pc<=0, issued_cnt<=0, done/pc_overflow/illegal cleared, go to FETCH.
  - prog_we and start in the same cycle: the write lands first, so FETCH sees the new word.
- FETCH (1 cycle): combinational read of mem[pc] and decode; results registered at the edge.
  - Word 0x00000073 (ecall): done<=1, go to HALT.
  - add (opcode 0110011, funct3 000, funct7 0000000): op 7'b0000010, rs1/rs2/rd from fields, rd_in 0.
  - sub (as add, funct7 0100000): op 7'b0000011.
  - li (opcode 0010011, funct3 000, rs1 field 0):
    - op 7'b0000001; rs1 output = instruction rd field, so the datapath stores rd_in there.
    - rd_in = sign-extended imm[31:20]; rs2=0; rd=0.
  - Any other encoding: illegal<=1, handled per Optional Feature.
  - On a legal decode: issue_valid<=1, go to ISSUE.
- ISSUE: all outputs held stable while issue_valid && !issue_ready. On the handshake edge:
  - issue_valid<=0; issued_cnt increments and saturates at all-ones.
  - If pc==DEPTH-1: pc_overflow<=1, go to HALT. Otherwise pc<=pc+1, go to FETCH.
- Throughput: 1 instruction per 2 cycles when issue_ready is held high. Latency from start to first issue_valid is 2 edges.
- start during FETCH or ISSUE is ignored.
- issue_ready while issue_valid=0 has no effect.

Optional Feature:
- Macro ISSUE_ILLEGAL_TRAP_EN.
- Defined: an illegal word sets illegal and moves to HALT; done stays 0; pc holds the offending address.
- Undefined: an illegal word is skipped and execution continues. illegal is set (sticky). No issue, no count. pc advances, or pc_overflow is set if pc==DEPTH-1.

Decomposition:
- Shared package processor_pkg holds:
  - datapath op codes OP_NOP/OP_STORE/OP_ADD/OP_SUB.
  - RV opcode/funct constants and the ECALL word.
  - the FSM state enum.
- One natural sub-module: instr_decoder, a purely combinational word-to-fields mapping with a legal flag. It is reused by future fetch stages.

Test Plan:
- Load [0]=0x00310533, [1]=0x00000073; start; ready=1 -> op 2, rs1 2, rs2 3, rd 10 issued once; then done=1, issued_cnt=1, busy=0.
- [0]=0x40520733 with ready low for 5 cycles -> issue_valid and op 3/rs1 4/rs2 5/rd 14 stable for 5 cycles; single accept; pc then 1.
- [0]=0xFFD00113 -> op 1, rs1 2, rd_in 0xFFFFFFFD, rs2 0.
- DEPTH=4, all add words, no ecall -> exactly 4 issues, then pc_overflow=1 with pc=3.
- [0]=0xFFFFFFFF, [1]=add, [2]=ecall -> with macro: HALT at pc 0, illegal=1, 0 issues. Without macro: add issued, done=1, illegal=1.
- rst_n low during ISSUE -> all outputs 0 asynchronously; a later start reruns the retained program from pc 0.
